mem_port_arbiter: RTL and testbench

//  Shares the CPU's single synchronous memory port between instruction fetch (IF) and load/store (LS).
//  Per cycle, grants at most one requester and drives memory with the winner's fields.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_starve_ctr.sv | 35 +++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Read-response owner encoding plus the byte masks driven onto the memory port.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam logic [3:0] MASK_WORD = 4'b1111;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    // Owner of the response returning next cycle; LS writes produce no response.
    function automatic owner_e next_owner(input logic if_gnt, input logic ls_gnt,
                                          input logic ls_we);
        if (if_gnt) begin
            return OWN_IF;
        end else if (ls_gnt && !ls_we) begin
            return OWN_LS;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles in which IF asked for the port and was denied.
// at_limit_o tells the arbiter to let IF win the next conflict.
module mem_arb_starve_ctr #(
    parameter int unsigned Limit = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam int unsigned CntW = $clog2(Limit + 1);
    localparam logic [CntW-1:0] LimitVal = CntW'(Limit);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Any cycle without a denied IF request (granted or idle) restarts the count.
    always_comb begin
        cnt_d = '0;
        if (inc_i) begin
            cnt_d = (cnt_q == LimitVal) ? cnt_q : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LimitVal);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single synchronous memory port between instruction fetch and load/store.
// Default is LS priority with an IF starvation guard; define MEM_PORT_ARB_RR_EN for round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_if_req,
    input  logic [29:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,

    input  logic        i_ls_req,
    input  logic [29:0] i_ls_addr,
    input  logic        i_ls_we,
    input  logic [3:0]  i_ls_mask,
    input  logic [31:0] i_ls_wdata,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [31:0] o_ls_rdata,

    output logic [29:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_mask,
    input  logic [31:0] i_mem_data
);

    logic   if_wins;
    owner_e rd_owner_q, rd_owner_d;

`ifdef MEM_PORT_ARB_RR_EN
    owner_e rr_last_q, rr_last_d;

    assign if_wins = !i_ls_req || (rr_last_q == OWN_LS);

    always_comb begin
        rr_last_d = rr_last_q;
        if (o_if_gnt) begin
            rr_last_d = OWN_IF;
        end else if (o_ls_gnt) begin
            rr_last_d = OWN_LS;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_q <= OWN_IF;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    logic starve_hit;

    mem_arb_starve_ctr #(
        .Limit(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .inc_i     (i_if_req && !o_if_gnt),
        .at_limit_o(starve_hit)
    );

    assign if_wins = !i_ls_req || starve_hit;
`endif

    assign o_if_gnt = rst_n && i_if_req && if_wins;
    assign o_ls_gnt = rst_n && i_ls_req && !o_if_gnt;

    always_comb begin
        o_mem_addr = '0;
        o_mem_data = '0;
        o_mem_we   = 1'b0;
        o_mem_mask = MASK_NONE;
        if (o_if_gnt) begin
            o_mem_addr = i_if_addr;
            o_mem_mask = MASK_WORD;
        end else if (o_ls_gnt) begin
            o_mem_addr = i_ls_addr;
            o_mem_data = i_ls_wdata;
            o_mem_we   = i_ls_we;
            o_mem_mask = i_ls_mask;
        end
    end

    assign rd_owner_d = next_owner(o_if_gnt, o_ls_gnt, i_ls_we);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    // Responses are suppressed while reset is held so a stale owner never leaks data.
    assign o_if_rvalid = rst_n && (rd_owner_q == OWN_IF);
    assign o_ls_rvalid = rst_n && (rd_owner_q == OWN_LS);
    assign o_if_rdata  = o_if_rvalid ? i_mem_data : '0;
    assign o_ls_rdata  = o_ls_rvalid ? i_mem_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we;
    logic [29:0] if_addr, ls_addr;
    logic [3:0]  ls_mask;
    logic [31:0] ls_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we;
    logic [31:0] if_rdata, ls_rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_mask;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: 0 none, 1 IF, 2 LS for the pending response owner.
    int m_starve;
    int m_owner;
    bit m_rr_last_ls;

    logic        obs_if_gnt, obs_ls_gnt, obs_if_rvalid, obs_ls_rvalid, obs_mem_we;
    logic [31:0] obs_if_rdata, obs_ls_rdata, obs_mem_wdata, obs_mem_in;
    logic [29:0] obs_mem_addr;
    logic [3:0]  obs_mem_mask;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_if_req   (if_req),
        .i_if_addr  (if_addr),
        .o_if_gnt   (if_gnt),
        .o_if_rvalid(if_rvalid),
        .o_if_rdata (if_rdata),
        .i_ls_req   (ls_req),
        .i_ls_addr  (ls_addr),
        .i_ls_we    (ls_we),
        .i_ls_mask  (ls_mask),
        .i_ls_wdata (ls_wdata),
        .o_ls_gnt   (ls_gnt),
        .o_ls_rvalid(ls_rvalid),
        .o_ls_rdata (ls_rdata),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_wdata),
        .o_mem_we   (mem_we),
        .o_mem_mask (mem_mask),
        .i_mem_data (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: inputs were set after the falling edge; check, then advance the model.
    task automatic cyc();
        bit          e_if, e_ls, e_ifv, e_lsv;
        logic [29:0] e_addr;
        logic [31:0] e_data;
        bit          e_we;
        logic [3:0]  e_mask;
        mem_rdata = $urandom;
        #1;
        e_if = 0;
        e_ls = 0;
        if (rst_n) begin
            if (if_req && ls_req) begin
`ifdef MEM_PORT_ARB_RR_EN
                e_if = m_rr_last_ls;
`else
                e_if = (m_starve >= LIMIT);
`endif
                e_ls = !e_if;
            end else begin
                e_if = if_req;
                e_ls = ls_req;
            end
        end
        e_addr = 0; e_data = 0; e_we = 0; e_mask = 4'b0000;
        if (e_if) begin
            e_addr = if_addr;
            e_mask = 4'b1111;
        end else if (e_ls) begin
            e_addr = ls_addr; e_data = ls_wdata; e_we = ls_we; e_mask = ls_mask;
        end
        e_ifv = rst_n && (m_owner == 1);
        e_lsv = rst_n && (m_owner == 2);

        chk("if_gnt", 32'(if_gnt), 32'(e_if));
        chk("ls_gnt", 32'(ls_gnt), 32'(e_ls));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_data", mem_wdata, e_data);
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_mask", 32'(mem_mask), 32'(e_mask));
        chk("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
        chk("ls_rvalid", 32'(ls_rvalid), 32'(e_lsv));
        chk("if_rdata", if_rdata, e_ifv ? mem_rdata : 32'h0);
        chk("ls_rdata", ls_rdata, e_lsv ? mem_rdata : 32'h0);

        if (!rst_n) begin
            m_starve = 0; m_rr_last_ls = 0; m_owner = 0;
        end else begin
            m_starve = (if_req && !e_if) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            if (e_if) m_rr_last_ls = 0;
            else if (e_ls) m_rr_last_ls = 1;
            m_owner = e_if ? 1 : ((e_ls && !ls_we) ? 2 : 0);
        end

        obs_if_gnt = if_gnt; obs_ls_gnt = ls_gnt;
        obs_if_rvalid = if_rvalid; obs_ls_rvalid = ls_rvalid;
        obs_if_rdata = if_rdata; obs_ls_rdata = ls_rdata;
        obs_mem_we = mem_we; obs_mem_addr = mem_addr; obs_mem_mask = mem_mask;
        obs_mem_wdata = mem_wdata; obs_mem_in = mem_rdata;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 0; ls_req = 0; ls_we = 0;
        if_addr = 0; ls_addr = 0; ls_mask = 0; ls_wdata = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         g, v;
        logic [5:0] pat;
        logic [5:0] exp_pat;

        m_starve = 0; m_owner = 0; m_rr_last_ls = 0;
        idle_inputs();
        rst_n = 0;
        mem_rdata = 0;
        @(negedge clk);
        cyc();
        do_reset();

        // IF alone: granted every cycle, data returns on cycles 2-4.
        g = 0; v = 0;
        for (int i = 1; i <= 4; i++) begin
            if_req  = (i <= 3);
            if_addr = 30'h10;
            cyc();
            if (i <= 3) g += int'(obs_if_gnt);
            if (i >= 2) v += int'(obs_if_rvalid && (obs_if_rdata == obs_mem_in));
        end
        chk("t1_if_grants", 32'(g), 32'd3);
        chk("t1_if_rvalids", 32'(v), 32'd3);

        // Conflict from a fresh reset: pattern of IF grants over six cycles (first cycle is MSB).
        idle_inputs();
        do_reset();
        if_req = 1; if_addr = 30'h100;
        ls_req = 1; ls_addr = 30'h200; ls_we = 0; ls_mask = 4'hF;
        pat = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            pat = {pat[4:0], obs_if_gnt};
        end
`ifdef MEM_PORT_ARB_RR_EN
        exp_pat = 6'b010101;
`else
        exp_pat = 6'b000010;
`endif
        chk("t2_if_grant_pattern", 32'(pat), 32'(exp_pat));
        idle_inputs();
        cyc();

        // LS write: passes straight through, no response follows.
        ls_req = 1; ls_we = 1; ls_mask = 4'b0011; ls_wdata = 32'hDEADBEEF; ls_addr = 30'h20;
        cyc();
        chk("t3_mem_we", 32'(obs_mem_we), 32'd1);
        chk("t3_mem_mask", 32'(obs_mem_mask), 32'h3);
        chk("t3_mem_wdata", obs_mem_wdata, 32'hDEADBEEF);
        idle_inputs();
        cyc();
        chk("t3_no_rvalid", 32'({obs_if_rvalid, obs_ls_rvalid}), 32'd0);

        // LS read then IF read back to back: responses land on the right side.
        ls_req = 1; ls_we = 0; ls_addr = 30'h4; ls_mask = 4'hF;
        cyc();
        ls_req = 0; if_req = 1; if_addr = 30'h8;
        cyc();
        chk("t4_ls_rvalid", 32'(obs_ls_rvalid), 32'd1);
        chk("t4_ls_rdata", obs_ls_rdata, obs_mem_in);
        chk("t4_if_quiet", 32'(obs_if_rvalid), 32'd0);
        idle_inputs();
        cyc();
        chk("t4_if_rvalid", 32'(obs_if_rvalid), 32'd1);
        chk("t4_ls_quiet", 32'(obs_ls_rvalid), 32'd0);

        // IF request during reset is not granted and leaves no response behind.
        if_req = 1; if_addr = 30'h10; rst_n = 0;
        cyc();
        chk("t5_gnt_in_reset", 32'(obs_if_gnt), 32'd0);
        rst_n = 1; if_req = 0;
        cyc();
        chk("t5_rvalid_after", 32'({obs_if_rvalid, obs_ls_rvalid}), 32'd0);
        chk("t5_mem_idle", 32'({obs_mem_we, obs_mem_mask, obs_mem_addr != 0}), 32'd0);

        // Idle: nothing moves for ten cycles.
        v = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            v += int'(obs_if_gnt || obs_ls_gnt || obs_if_rvalid || obs_ls_rvalid ||
                      obs_mem_we || (obs_mem_mask != 0));
        end
        chk("t6_idle_activity", 32'(v), 32'd0);

        // Random traffic; requesters hold their fields until granted.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (!if_req || obs_if_gnt) begin
                if_req  = ($urandom_range(0, 99) < 60);
                if_addr = 30'($urandom);
            end
            if (!ls_req || obs_ls_gnt) begin
                ls_req   = ($urandom_range(0, 99) < 60);
                ls_addr  = 30'($urandom);
                ls_we    = $urandom_range(0, 1) == 1;
                ls_mask  = 4'($urandom);
                ls_wdata = $urandom;
            end
            cyc();
            chk("gnt_exclusive", 32'(obs_if_gnt && obs_ls_gnt), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
